implication_monitor: RTL and testbench
======================================

Name: implication_monitor

Overview:
- Synthesizable run-time checker for the implication property "ANTE |-> ##DELAY CONS". It is the checking side of a registered path such as a flip-flop stage.
- Each sampled antecedent is tracked as an outstanding obligation. The consequent is checked DELAY clock edges later.
- Failures are reported as a pulse, a saturating count and a sticky flag.
- Intended for FPGA or emulation builds where simulator assertions are not available. It sits beside the logic under check and feeds the debug status registers.

Parameters:
- DELAY, 1, clock edges between sampling the antecedent and checking the consequent. Legal range 1..16; any other value is an elaboration error.
- CNT_W, 8, width of the failure counter and the match counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  when high, a high ANTE creates an obligation; when low, no new obligations are created.
- ANTE  input  1  antecedent.
- CONS  input  1  consequent.
- CLEAR  input  1  synchronous clear of the counters and the sticky flag.
- PENDING  output  1  high while any obligation is outstanding.
- FAIL  output  1  one-cycle registered failure pulse.
- FAIL_STICKY  output  1  high from the first failure until CLEAR or RESET.
- FAIL_COUNT  output  CNT_W  saturating count of failures.
- MATCH_COUNT  output  CNT_W  saturating count of matches. Present only with IMPL_MON_COVER_EN.

Behaviour:
- Clock and reset: one clock, CLK; reset RESET is synchronous and active-high.
- Reset values: obligation pipe 0, PENDING 0, FAIL 0, FAIL_STICKY 0, FAIL_COUNT 0, MATCH_COUNT 0.
- Obligation pipe:
  - DELAY-bit shift register, pipe[0] <= EN & ANTE, pipe[i] <= pipe[i-1].
  - due = pipe[DELAY-1] is the obligation that matures at the current edge.
- Timing: antecedent sampled at edge k; CONS sampled at edge k+DELAY; FAIL high for the cycle following edge k+DELAY.
  - Example, DELAY=1: ANTE at edge k, CONS checked at edge k+1.
- Per-edge evaluation:
  - Failure: due & ~CONS. Sets FAIL <= 1 and FAIL_STICKY <= 1, and increments FAIL_COUNT.
  - Match: due & CONS. FAIL <= 0; MATCH_COUNT increments when enabled.
  - Otherwise FAIL <= 0.
- Overlapping obligations: each ANTE cycle is an independent obligation. Back-to-back ANTE produces back-to-back checks, with no merging.
- EN low: suppresses new obligations only. Obligations already in the pipe still mature and are checked.
- PENDING = OR of all pipe bits. Combinational from registers; no input-to-output paths.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - FAIL_STICKY stays 1 while saturated.
- CLEAR:
  - Sets FAIL_COUNT, MATCH_COUNT and FAIL_STICKY to 0. Has priority over a same-edge increment or set.
  - Does not touch the pipe or FAIL. A same-edge failure still pulses FAIL, but the count stays 0.
- RESET mid-operation: discards all outstanding obligations. No failure is reported for them.
- RESET has priority over CLEAR and over all other updates.
- Simultaneous new antecedent and maturing obligation: both are handled in the same edge, independently.

Optional Feature:
- Macro IMPL_MON_COVER_EN.
- Defined: MATCH_COUNT port and counter exist, with the saturate/CLEAR/RESET rules above.
- Undefined: MATCH_COUNT port and logic are absent; all other behaviour is identical.

Decomposition:
- Package impl_mon_pkg holds:
  - localparam DELAY_MAX = 16;
  - a function that checks DELAY legality;
  - typedef for the status bundle {sticky, fail_count}, for use by debug register blocks.
- Sub-module impl_mon_sat_cnt (parameter W; inputs CLK, RESET, CLEAR, INC; output Q): saturating counter. It is instantiated once for the failure count and, under the macro, once for the match count.

Test Plan:
- DELAY=1: ANTE=1, EN=1 at edge 3, CONS=1 at edge 4 -> FAIL stays 0, FAIL_COUNT=0, MATCH_COUNT=1; PENDING high between edges 3 and 4 only.
- DELAY=3: ANTE pulses at edges 2,3,4, CONS high at edges 5 and 7 only -> FAIL high only after edge 6, FAIL_COUNT=1, FAIL_STICKY=1, MATCH_COUNT=2.
- EN drops at edge 5 after ANTE at edge 4 (DELAY=2), CONS=0 at edge 6 -> failure still reported, FAIL_COUNT=1; ANTE at edge 5 is ignored.
- CNT_W=2: 5 consecutive failures -> FAIL_COUNT reaches 3 and stays at 3; CLEAR on the same edge as a 6th failure -> FAIL pulses, FAIL_COUNT=0, FAIL_STICKY=0.
- DELAY=4: ANTE at edges 1..3, RESET at edge 3 -> PENDING=0 after edge 3, no FAIL at edges 5..7 even with CONS=0.
- Build without IMPL_MON_COVER_EN -> MATCH_COUNT absent; rerun scenario 1 -> identical FAIL and FAIL_COUNT results.

Source files
------------

// File: rtl/impl_mon_pkg.sv
// Shared definitions for the implication monitor: the DELAY limit, a
// DELAY legality check, and the status bundle read by debug register blocks.
package impl_mon_pkg;

  localparam int DELAY_MAX = 16;

  // Counter width used by the status bundle typedef below.
  localparam int STATUS_CNT_W = 8;

  // True when the antecedent-to-consequent distance is one the pipe supports.
  function automatic bit delay_is_legal(input int delay);
    return (delay >= 1) && (delay <= DELAY_MAX);
  endfunction

  // Status bundle for debug register blocks: sticky flag plus failure count.
  typedef struct packed {
    logic                    sticky;
    logic [STATUS_CNT_W-1:0] fail_count;
  } impl_mon_status_t;

endpackage

// File: rtl/impl_mon_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear. It holds at
// all-ones instead of wrapping, so a long burst of events never reads as few.
module impl_mon_sat_cnt
  import impl_mon_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLEAR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  // Reset and clear win over an increment; the count sticks at its maximum.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= '0;
    end else if (CLEAR) begin
      Q <= '0;
    end else if (INC && (Q != {W{1'b1}})) begin
      Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/implication_monitor.sv
// Run-time checker for "ANTE |-> ##DELAY CONS".
// Every enabled antecedent enters a DELAY-deep obligation pipe; when it
// reaches the end, CONS is checked on that edge. Failures give a one-cycle
// FAIL pulse, a sticky flag and a saturating count.
// Optional build macro: IMPL_MON_COVER_EN adds the MATCH_COUNT port and
// its saturating match counter.
module implication_monitor
  import impl_mon_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             ANTE,
  input  logic             CONS,
  input  logic             CLEAR,
  output logic             PENDING,
  output logic             FAIL,
  output logic             FAIL_STICKY,
  output logic [CNT_W-1:0] FAIL_COUNT
`ifdef IMPL_MON_COVER_EN
  ,
  output logic [CNT_W-1:0] MATCH_COUNT
`endif
);

  // An out-of-range DELAY cannot be built, so stop elaboration.
  if (!delay_is_legal(DELAY)) begin : g_bad_delay
    $error("implication_monitor: DELAY must be in 1..16");
  end

  logic [DELAY-1:0] pipe;
  logic             due;
  logic             fail_now;
  logic             match_now;

  assign due       = pipe[DELAY-1];
  assign fail_now  = due & ~CONS;
  assign match_now = due & CONS;
  assign PENDING   = |pipe;

  // Obligation pipe: each enabled antecedent is an independent bit shifted toward maturity.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe <= '0;
    end else begin
      for (int i = DELAY - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0] <= EN & ANTE;
    end
  end

  // Failure pulse follows the maturing obligation; CLEAR deliberately does not mask it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FAIL <= 1'b0;
    end else begin
      FAIL <= fail_now;
    end
  end

  // Sticky flag latches the first failure and only drops on CLEAR or RESET.
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      FAIL_STICKY <= 1'b0;
    end else if (fail_now) begin
      FAIL_STICKY <= 1'b1;
    end
  end

  impl_mon_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (CLEAR),
    .INC   (fail_now),
    .Q     (FAIL_COUNT)
  );

`ifdef IMPL_MON_COVER_EN
  impl_mon_sat_cnt #(.W(CNT_W)) u_match_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (CLEAR),
    .INC   (match_now),
    .Q     (MATCH_COUNT)
  );
`else
  logic unused_match;
  assign unused_match = match_now;
`endif

endmodule

// File: tb/tb_implication_monitor.sv
// Directed bench for implication_monitor. Several instances with different
// DELAY/CNT_W share one stimulus bus; each scenario checks its own instance.
// MATCH_COUNT checks are compiled only when IMPL_MON_COVER_EN is defined.
module tb_implication_monitor;

  logic CLK = 1'b0;
  logic RESET, EN, ANTE, CONS, CLEAR;

  int checks = 0;
  int errors = 0;

  // Outputs of the DELAY=1 instance
  logic       pend1, fail1, stk1;
  logic [7:0] fcnt1, mcnt1;
  // Outputs of the DELAY=3 instance
  logic       pend3, fail3, stk3;
  logic [7:0] fcnt3, mcnt3;
  // Outputs of the DELAY=2 instance
  logic       pend2, fail2, stk2;
  logic [7:0] fcnt2, mcnt2;
  // Outputs of the DELAY=1, CNT_W=2 instance
  logic       pends, fails, stks;
  logic [1:0] fcnts, mcnts;
  // Outputs of the DELAY=4 instance
  logic       pend4, fail4, stk4;
  logic [7:0] fcnt4, mcnt4;

  // Free-running clock, period 10
  always #5 CLK = ~CLK;

  implication_monitor #(.DELAY(1), .CNT_W(8)) u_d1 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .ANTE(ANTE), .CONS(CONS), .CLEAR(CLEAR),
    .PENDING(pend1), .FAIL(fail1), .FAIL_STICKY(stk1), .FAIL_COUNT(fcnt1)
`ifdef IMPL_MON_COVER_EN
    , .MATCH_COUNT(mcnt1)
`endif
  );

  implication_monitor #(.DELAY(3), .CNT_W(8)) u_d3 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .ANTE(ANTE), .CONS(CONS), .CLEAR(CLEAR),
    .PENDING(pend3), .FAIL(fail3), .FAIL_STICKY(stk3), .FAIL_COUNT(fcnt3)
`ifdef IMPL_MON_COVER_EN
    , .MATCH_COUNT(mcnt3)
`endif
  );

  implication_monitor #(.DELAY(2), .CNT_W(8)) u_d2 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .ANTE(ANTE), .CONS(CONS), .CLEAR(CLEAR),
    .PENDING(pend2), .FAIL(fail2), .FAIL_STICKY(stk2), .FAIL_COUNT(fcnt2)
`ifdef IMPL_MON_COVER_EN
    , .MATCH_COUNT(mcnt2)
`endif
  );

  implication_monitor #(.DELAY(1), .CNT_W(2)) u_sat (
    .CLK(CLK), .RESET(RESET), .EN(EN), .ANTE(ANTE), .CONS(CONS), .CLEAR(CLEAR),
    .PENDING(pends), .FAIL(fails), .FAIL_STICKY(stks), .FAIL_COUNT(fcnts)
`ifdef IMPL_MON_COVER_EN
    , .MATCH_COUNT(mcnts)
`endif
  );

  implication_monitor #(.DELAY(4), .CNT_W(8)) u_d4 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .ANTE(ANTE), .CONS(CONS), .CLEAR(CLEAR),
    .PENDING(pend4), .FAIL(fail4), .FAIL_STICKY(stk4), .FAIL_COUNT(fcnt4)
`ifdef IMPL_MON_COVER_EN
    , .MATCH_COUNT(mcnt4)
`endif
  );

`ifndef IMPL_MON_COVER_EN
  assign mcnt1 = '0;
  assign mcnt3 = '0;
  assign mcnt2 = '0;
  assign mcnts = '0;
  assign mcnt4 = '0;
`endif

  // Drive one cycle of inputs away from the edge, then sample just after the edge
  task automatic applyStimulus(input logic rst, input logic en, input logic ante,
                               input logic cons, input logic clr);
    @(negedge CLK);
    RESET = rst;
    EN    = en;
    ANTE  = ante;
    CONS  = cons;
    CLEAR = clr;
    @(posedge CLK);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, run one after another with a reset in front of each
  initial begin
    RESET = 1'b1; EN = 1'b0; ANTE = 1'b0; CONS = 1'b0; CLEAR = 1'b0;

    // Scenario 1: DELAY=1, antecedent then consequent one edge later
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s1_reset_pending", {7'd0, pend1}, 8'd0);
    checkOutput("s1_reset_fail",    {7'd0, fail1}, 8'd0);
    checkOutput("s1_reset_sticky",  {7'd0, stk1},  8'd0);
    checkOutput("s1_reset_count",   fcnt1,         8'd0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s1_pending_high",  {7'd0, pend1}, 8'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s1_pending_low",   {7'd0, pend1}, 8'd0);
    checkOutput("s1_fail",          {7'd0, fail1}, 8'd0);
    checkOutput("s1_fail_count",    fcnt1,         8'd0);
`ifdef IMPL_MON_COVER_EN
    checkOutput("s1_match_count",   mcnt1,         8'd1);
`endif

    // Scenario 2: DELAY=3, three overlapping obligations, middle one fails
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s2_pending",       {7'd0, pend3}, 8'd1);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("s2_fail_e5",       {7'd0, fail3}, 8'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("s2_fail_e6",       {7'd0, fail3}, 8'd1);
    checkOutput("s2_sticky_e6",     {7'd0, stk3},  8'd1);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("s2_fail_e7",       {7'd0, fail3}, 8'd0);
    checkOutput("s2_fail_count",    fcnt3,         8'd1);
    checkOutput("s2_sticky",        {7'd0, stk3},  8'd1);
    checkOutput("s2_pending_done",  {7'd0, pend3}, 8'd0);
`ifdef IMPL_MON_COVER_EN
    checkOutput("s2_match_count",   mcnt3,         8'd2);
`endif

    // Scenario 3: DELAY=2, EN drops after an antecedent; pending one still checked
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("s3_pending_e5",    {7'd0, pend2}, 8'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s3_fail_e6",       {7'd0, fail2}, 8'd1);
    checkOutput("s3_count_e6",      fcnt2,         8'd1);
    checkOutput("s3_pending_e6",    {7'd0, pend2}, 8'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s3_fail_e7",       {7'd0, fail2}, 8'd0);
    checkOutput("s3_count_e7",      fcnt2,         8'd1);

    // Scenario 4: CNT_W=2, saturation then CLEAR against a same-edge failure
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s4_count_1",       {6'd0, fcnts}, 8'd1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s4_count_2",       {6'd0, fcnts}, 8'd2);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s4_count_3",       {6'd0, fcnts}, 8'd3);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s4_count_sat4",    {6'd0, fcnts}, 8'd3);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s4_count_sat5",    {6'd0, fcnts}, 8'd3);
    checkOutput("s4_sticky_sat",    {7'd0, stks},  8'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s4_clear_fail",    {7'd0, fails}, 8'd1);
    checkOutput("s4_clear_count",   {6'd0, fcnts}, 8'd0);
    checkOutput("s4_clear_sticky",  {7'd0, stks},  8'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s4_after_fail",    {7'd0, fails}, 8'd0);
    checkOutput("s4_after_count",   {6'd0, fcnts}, 8'd0);

    // Scenario 5: DELAY=4, RESET mid-flight discards obligations silently
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("s5_pending_e1",    {7'd0, pend4}, 8'd1);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("s5_pending_rst",   {7'd0, pend4}, 8'd0);
    for (int e = 4; e <= 8; e++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("s5_fail_e%0d", e), {7'd0, fail4}, 8'd0);
    end
    checkOutput("s5_count",         fcnt4,         8'd0);
    checkOutput("s5_sticky",        {7'd0, stk4},  8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
